// File: rtl/cdb_scheduler.sv
// cdb_scheduler
// Single-port issue scheduler and CDB slot reserver for the Tomasulo back end.
// It arbitrates the shared operand port between the int, load-buffer, mult and
// div issue queues. It reserves the broadcast cycle of each granted result in a
// shifting reservation table. It then replays the table head as the CDB
// select/tag/valid triple.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ready_<q>, rdtag_<q>           queue head ready / destination tag
//   issue_<q>                      grant (at most one per cycle)
//   div_busy                       divider occupied
//   cdb_valid, cdb_sel, cdb_tagout broadcast in this cycle (sel 0=int 1=ld 2=mult 3=div)
module cdb_scheduler #(
  parameter int unsigned INT_LAT  = 1,
  parameter int unsigned LD_LAT   = 1,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_int,
  input  logic       ready_ld_buf,
  input  logic       ready_mult,
  input  logic       ready_div,
  input  logic [5:0] rdtag_int,
  input  logic [5:0] rdtag_ld_buf,
  input  logic [5:0] rdtag_mult,
  input  logic [5:0] rdtag_div,
  output logic       issue_int,
  output logic       issue_ld_buf,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       div_busy,
  output logic       cdb_valid,
  output logic [1:0] cdb_sel,
  output logic [5:0] cdb_tagout
);

  // Reservation table: entry k holds the broadcast k cycles from now.
  logic [DIV_LAT-1:0] vld_q, vld_d;
  logic [1:0]         sel_q [DIV_LAT];
  logic [1:0]         sel_d [DIV_LAT];
  logic [5:0]         tag_q [DIV_LAT];
  logic [5:0]         tag_d [DIV_LAT];

  logic [3:0] cnt_q, cnt_d;
  logic       lru_q, lru_d;

  // Slot-free vector with one extra always-free position at index DIV_LAT,
  // so a unit whose latency equals DIV_LAT never sees its slot taken.
  logic [DIV_LAT:0] free;
  assign free = {1'b1, ~vld_q};

  logic elig_int, elig_ld, elig_mult, elig_div;
  logic g_int, g_ld, g_mult, g_div;

  assign div_busy  = (cnt_q != 4'd0);
  assign elig_int  = ready_int    & free[INT_LAT];
  assign elig_ld   = ready_ld_buf & free[LD_LAT];
  assign elig_mult = ready_mult   & free[MULT_LAT];
  assign elig_div  = ready_div    & ~div_busy;

  always_comb begin
    g_int  = 1'b0;
    g_ld   = 1'b0;
    g_mult = 1'b0;
    g_div  = 1'b0;
    if (!reset) begin
      if (elig_div)                 g_div  = 1'b1;
      else if (elig_mult)           g_mult = 1'b1;
      else if (elig_int && elig_ld) begin
        if (lru_q) g_ld  = 1'b1;
        else       g_int = 1'b1;
      end
      else if (elig_int)            g_int  = 1'b1;
      else if (elig_ld)             g_ld   = 1'b1;
    end
  end

  assign issue_int    = g_int;
  assign issue_ld_buf = g_ld;
  assign issue_mult   = g_mult;
  assign issue_div    = g_div;

  // Shift the table by one and drop the new grant into slot L-1. That slot
  // always receives an empty entry from the shift because eligibility
  // checked R[L].
  always_comb begin
    vld_d = '0;
    for (int unsigned k = 0; k < DIV_LAT; k++) begin
      sel_d[k] = '0;
      tag_d[k] = '0;
    end
    for (int unsigned k = 0; k + 1 < DIV_LAT; k++) begin
      vld_d[k] = vld_q[k+1];
      sel_d[k] = sel_q[k+1];
      tag_d[k] = tag_q[k+1];
    end
    if (g_int) begin
      vld_d[INT_LAT-1] = 1'b1;
      sel_d[INT_LAT-1] = 2'b00;
      tag_d[INT_LAT-1] = rdtag_int;
    end
    if (g_ld) begin
      vld_d[LD_LAT-1] = 1'b1;
      sel_d[LD_LAT-1] = 2'b01;
      tag_d[LD_LAT-1] = rdtag_ld_buf;
    end
    if (g_mult) begin
      vld_d[MULT_LAT-1] = 1'b1;
      sel_d[MULT_LAT-1] = 2'b10;
      tag_d[MULT_LAT-1] = rdtag_mult;
    end
    if (g_div) begin
      vld_d[DIV_LAT-1] = 1'b1;
      sel_d[DIV_LAT-1] = 2'b11;
      tag_d[DIV_LAT-1] = rdtag_div;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (g_div)             cnt_d = 4'(DIV_LAT - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 4'd1;
    lru_d = lru_q;
    if (g_int)      lru_d = 1'b1;
    else if (g_ld)  lru_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
        sel_q[k] <= '0;
        tag_q[k] <= '0;
      end
      cnt_q <= '0;
      lru_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
        sel_q[k] <= sel_d[k];
        tag_q[k] <= tag_d[k];
      end
      cnt_q <= cnt_d;
      lru_q <= lru_d;
    end
  end

  assign cdb_valid  = vld_q[0];
  assign cdb_sel    = vld_q[0] ? sel_q[0] : 2'b00;
  assign cdb_tagout = vld_q[0] ? tag_q[0] : 6'd0;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler. The reference model keeps a broadcast schedule
// indexed by absolute cycle number, together with the cycle of the last
// divider issue and the int/ld fairness bit.
module tb_cdb_scheduler;
  localparam int unsigned IL = 1, LL = 1, ML = 4, DL = 7;
  localparam int NSLOT = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] rdy;             // 0=int 1=ld 2=mult 3=div
  logic [5:0] tg [4];
  logic       issue_int, issue_ld_buf, issue_mult, issue_div;
  logic       div_busy, cdb_valid;
  logic [1:0] cdb_sel;
  logic [5:0] cdb_tagout;

  cdb_scheduler #(.INT_LAT(IL), .LD_LAT(LL), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset),
    .ready_int(rdy[0]), .ready_ld_buf(rdy[1]), .ready_mult(rdy[2]), .ready_div(rdy[3]),
    .rdtag_int(tg[0]), .rdtag_ld_buf(tg[1]), .rdtag_mult(tg[2]), .rdtag_div(tg[3]),
    .issue_int(issue_int), .issue_ld_buf(issue_ld_buf),
    .issue_mult(issue_mult), .issue_div(issue_div),
    .div_busy(div_busy), .cdb_valid(cdb_valid), .cdb_sel(cdb_sel), .cdb_tagout(cdb_tagout)
  );

  int unsigned lat [4] = '{IL, LL, ML, DL};
  logic [8:0]  sched [NSLOT];   // {valid, sel, tag} broadcast in that cycle
  int          t;
  bit          lru;
  int          last_div;
  logic [3:0]  exp_g;
  int          passed = 0;
  int          total  = 0;

  // One clock cycle: apply reset level, check outputs, advance the model.
  task automatic cycle(input bit rst);
    logic [3:0] el;
    logic [3:0] g;
    bit         busy;
    reset = rst;
    #1;
    busy = (t > last_div) && (t < last_div + int'(DL));
    for (int u = 0; u < 4; u++)
      el[u] = rdy[u] && !sched[t + int'(lat[u])][8] && (u != 3 || !busy);
    g = '0;
    if (!rst) begin
      if (el[3])               g[3] = 1'b1;
      else if (el[2])          g[2] = 1'b1;
      else if (el[0] && el[1]) g[lru ? 1 : 0] = 1'b1;
      else if (el[0])          g[0] = 1'b1;
      else if (el[1])          g[1] = 1'b1;
    end
    total++;
    assert ({issue_div, issue_mult, issue_ld_buf, issue_int} === g) passed++;
    else $error("FAIL issue t=%0d got %b want %b", t,
                {issue_div, issue_mult, issue_ld_buf, issue_int}, g);
    total++;
    assert (div_busy === busy) passed++;
    else $error("FAIL div_busy t=%0d got %b want %b", t, div_busy, busy);
    total++;
    assert ({cdb_valid, cdb_sel, cdb_tagout} === sched[t]) passed++;
    else $error("FAIL cdb t=%0d got %h want %h", t, {cdb_valid, cdb_sel, cdb_tagout}, sched[t]);
    if (rst) begin
      for (int k = 1; k <= int'(DL); k++) sched[t + k] = '0;
      lru = 1'b0;
      last_div = -100;
    end else begin
      for (int u = 0; u < 4; u++) if (g[u]) begin
        sched[t + int'(lat[u])] = {1'b1, 2'(u), tg[u]};
        if (u == 3) last_div = t;
        if (u == 0) lru = 1'b1;
        if (u == 1) lru = 1'b0;
      end
    end
    exp_g = g;
    t++;
    @(posedge clk);
    #1;
  endtask

  // Requesters hold ready/tag until granted.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0);
      rdy = rdy & ~exp_g;
    end
  endtask

  initial begin
    for (int i = 0; i < NSLOT; i++) sched[i] = '0;
    t = 0; lru = 1'b0; last_div = -100; exp_g = '0;
    rdy = '0;
    for (int u = 0; u < 4; u++) tg[u] = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1);

    total++;
    assert ({issue_int, issue_ld_buf, issue_mult, issue_div, div_busy, cdb_valid,
             cdb_sel, cdb_tagout} === 14'd0) passed++;
    else $error("FAIL reset_state got %h want 0",
                {issue_int, issue_ld_buf, issue_mult, issue_div, div_busy, cdb_valid,
                 cdb_sel, cdb_tagout});

    // Integer issue
    rdy[0] = 1'b1; tg[0] = 6'h05;
    run(3);
    // Mult/int collision
    rdy[2] = 1'b1; tg[2] = 6'h0A;
    run(3);
    rdy[0] = 1'b1; tg[0] = 6'h0B;
    run(6);
    // Divider busy and priority
    rdy[3] = 1'b1; tg[3] = 6'h21; rdy[2] = 1'b1; tg[2] = 6'h22;
    run(1);
    rdy[3] = 1'b1; tg[3] = 6'h23;
    run(16);
    // Div/mult slot clash
    rdy[3] = 1'b1; tg[3] = 6'h30;
    run(3);
    rdy[2] = 1'b1; tg[2] = 6'h31;
    run(10);
    // Fairness after reset
    cycle(1'b1);
    for (int i = 0; i < 4; i++) begin
      rdy[0] = 1'b1; tg[0] = 6'(8'h10 + i);
      rdy[1] = 1'b1; tg[1] = 6'(8'h18 + i);
      run(1);
    end
    rdy = '0;
    run(3);
    // Reset mid-flight
    rdy[2] = 1'b1; tg[2] = 6'h3F;
    run(2);
    cycle(1'b1);
    run(6);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      for (int u = 0; u < 4; u++)
        if (!rdy[u] && $urandom_range(0, 99) < 45) begin
          rdy[u] = 1'b1;
          tg[u] = 6'($urandom);
        end
      if ($urandom_range(0, 79) == 0) begin
        cycle(1'b1);
        rdy = rdy & ~exp_g;
      end else begin
        run(1);
      end
    end
    rdy = '0;
    run(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Single-port issue scheduler and common-data-bus (CDB) slot reserver for the Tomasulo back end. It arbitrates the one shared operand port between the integer, load-buffer, multiplier and divider issue queues. It reserves the CDB cycle on which each granted result will broadcast, so that no two results ever collide. It then replays each reservation as a CDB select/tag/valid triple in the broadcast cycle, which drives the CDB output mux downstream.

## Interface
Parameters:
- INT_LAT, default 1: issue-to-CDB latency of the integer unit.
- LD_LAT, default 1: issue-to-CDB latency of the load buffer.
- MULT_LAT, default 4: issue-to-CDB latency of the pipelined multiplier.
- DIV_LAT, default 7: issue-to-CDB latency of the divider, which is not pipelined.
- Constraints: 1 <= INT_LAT, LD_LAT, MULT_LAT <= DIV_LAT <= 15.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- ready_int / ready_ld_buf / ready_mult / ready_div, input, 1 each: queue has an instruction ready to issue.
- rdtag_int / rdtag_ld_buf / rdtag_mult / rdtag_div, input, 6 each: destination tag of that queue's head.
- issue_int / issue_ld_buf / issue_mult / issue_div, output, 1 each: grant. At most one is high per cycle.
- div_busy, output, 1: divider occupied.
- cdb_valid, output, 1: a result broadcasts this cycle.
- cdb_sel, output, 2: source of the broadcast. 00 = int, 01 = ld_buf, 10 = mult, 11 = div.
- cdb_tagout, output, 6: tag of the broadcast result.

## Operation
- Reservation table R[0..DIV_LAT-1]. Each entry is {valid, sel[1:0], tag[5:0]}. An entry at index k at cycle t means a broadcast in cycle t+k.
- Every clock edge, the table shifts: R[k] <= R[k+1]. R[DIV_LAT-1] fills with empty unless written by a grant.
- A grant of a unit with latency L in cycle t writes {1, sel, rdtag} into R[L-1]. The new entry therefore reaches R[0] in cycle t+L.
- Eligibility in cycle t requires all of the following:
  - the unit's ready is high;
  - the current R[L] is empty, or L == DIV_LAT (index out of range, always free);
  - for the divider only, div_busy is low.
- Fixed priority among eligible units: div > mult > {int, ld_buf}.
- int vs ld_buf: when both are eligible and neither higher-priority unit is granted, an LRU bit picks the one granted less recently.
  - lru = 0 favors int.
  - lru updates only on an int or ld_buf grant, and then points to the other unit.
  - When only one of the two is eligible, it is granted and lru still updates.
- Grants are combinational from the ready inputs and registered state. A requester holds ready and its rdtag until it is granted. A grant completes the handshake in the same cycle.
- Divider occupancy:
  - A 4-bit down-counter loads DIV_LAT-1 on issue_div.
  - It decrements while non-zero.
  - div_busy = (counter != 0). A new div can therefore issue in the cycle its predecessor broadcasts.
- CDB outputs are taken directly from the registered R[0]: cdb_valid = R[0].valid, with sel and tag likewise. When R[0] is not valid, sel and tag are 0.
- Reset:
  - Clears every table entry, the counter and lru.
  - All grants are forced to 0 while reset is high.
  - Reset mid-operation discards all in-flight reservations. No broadcast occurs for them.

## Timing
- Reset values: issue_* = 0, div_busy = 0, cdb_valid = 0, cdb_sel = 00, cdb_tagout = 0, lru = 0.
- Grant latency is 0 cycles from ready, provided the unit is eligible.
- A unit granted in cycle t broadcasts in cycle t+L exactly, with one broadcast per cycle.
- Throughput: one grant per cycle. div is limited to one per DIV_LAT cycles.
- Simultaneous broadcast-slot conflict: the earlier grant keeps the slot. The later requester stalls until its R[L] is free.

## Test plan
- Integer issue: ready_int=1 with rdtag_int=6'h05 at cycle 0 -> issue_int=1 at cycle 0; at cycle 1, cdb_valid=1, cdb_sel=00, cdb_tagout=05; at cycle 2, cdb_valid=0.
- Mult/int collision: mult granted at cycle 0 with tag 0A; ready_int held from cycle 3 with tag 0B -> int blocked at cycle 3 and granted at cycle 4; CDB shows 0A/sel 10 at cycle 4 and 0B/sel 00 at cycle 5.
- Divider busy and priority: ready_div and ready_mult both high at cycle 0 -> issue_div at cycle 0, mult granted at cycle 1; div_busy=1 for cycles 1-6; a second div is granted at cycle 7; the first div broadcasts at cycle 7 with sel 11.
- Div/mult slot clash: div granted at cycle 0; ready_mult held from cycle 3 -> mult blocked at cycle 3 and granted at cycle 4; broadcasts occur at cycles 7 (div) and 8 (mult).
- LRU fairness: ready_int and ready_ld_buf held high for 4 cycles after reset -> grants alternate int, ld_buf, int, ld_buf; broadcasts occur at cycles 1-4 with alternating sel.
- Reset mid-flight: mult granted at cycle 0, reset asserted at cycle 2 -> cdb_valid stays 0 through cycle 6, and all outputs hold their reset values during and after reset.
